// File: rtl/mcdec_fsm.sv
// Multi-cycle LEGv8 control FSM: FETCH/DECODE/EXEC/MEM/WB with an EXC trap state.
// Define MCDEC_EXC_EN to enable undefined-op, interrupt and memory-timeout traps.
module mcdec_fsm #(
  parameter int OP_W        = 11,
  parameter int MEM_TIMEOUT = 8,
  parameter int ALUOP_W     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    Op,
  input  logic               mem_ack,
  input  logic               ext_irq,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               Reg2Loc,
  output logic               ALUSrc,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               Branch,
  output logic               ERet,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               Exc,
  output logic [1:0]         ExcCause,
  output logic [2:0]         state_o
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_EXC    = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    OC_R, OC_LDUR, OC_STUR, OC_CBZ, OC_ERET, OC_MRS, OC_UNDEF
  } opc_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              instr_end;
  opc_e              op_cls;
  logic [10:0]       op11;

  assign op11 = Op[OP_W-1 -: 11];

  always_comb begin
    casez (op11)
      11'b1?0_0101_1000,
      11'b10?_0101_0000: op_cls = OC_R;
      11'b111_1100_0010: op_cls = OC_LDUR;
      11'b111_1100_0000: op_cls = OC_STUR;
      11'b101_1010_0???: op_cls = OC_CBZ;
      11'b110_1011_0100: op_cls = OC_ERET;
      11'b110_1010_1001: op_cls = OC_MRS;
      default:           op_cls = OC_UNDEF;
    endcase
  end

`ifdef MCDEC_EXC_EN
  localparam logic [1:0] CAUSE_UNDEF = 2'd1;
  localparam logic [1:0] CAUSE_IRQ   = 2'd2;
  localparam logic [1:0] CAUSE_TMO   = 2'd3;
  logic       irq_pend_q, irq_pend_d;
  logic [1:0] cause_q, cause_d;
`else
  logic unused_irq;
  assign unused_irq = ext_irq;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    instr_end = 1'b0;
`ifdef MCDEC_EXC_EN
    irq_pend_d = irq_pend_q | ext_irq;
    cause_d    = cause_q;
`endif
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (op_cls == OC_UNDEF) begin
`ifdef MCDEC_EXC_EN
          state_d = S_EXC;
          cause_d = CAUSE_UNDEF;
`else
          state_d = S_FETCH;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_cls)
          OC_R, OC_MRS: state_d = S_WB;
          OC_LDUR, OC_STUR: begin
            state_d = S_MEM;
            cnt_d   = '0;
          end
          default: instr_end = 1'b1;
        endcase
      end
      S_MEM: begin
        // An ack in the last allowed cycle beats the timeout.
        if (mem_ack) begin
          if (op_cls == OC_LDUR) state_d = S_WB;
          else                   instr_end = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
`ifdef MCDEC_EXC_EN
          state_d = S_EXC;
          cause_d = CAUSE_TMO;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB:    instr_end = 1'b1;
      S_EXC:   instr_end = 1'b1;
      default: state_d = S_FETCH;
    endcase
    if (instr_end) begin
      state_d = S_FETCH;
`ifdef MCDEC_EXC_EN
      if (irq_pend_q) begin
        state_d    = S_EXC;
        cause_d    = CAUSE_IRQ;
        irq_pend_d = ext_irq;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      cnt_q      <= '0;
`ifdef MCDEC_EXC_EN
      irq_pend_q <= 1'b0;
      cause_q    <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
`ifdef MCDEC_EXC_EN
      irq_pend_q <= irq_pend_d;
      cause_q    <= cause_d;
`endif
    end
  end

  // Controls decode from state and Op; reset forces them low immediately.
  always_comb begin
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    Reg2Loc  = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Branch   = 1'b0;
    ERet     = 1'b0;
    ALUOp    = '0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
        S_EXEC: begin
          ALUSrc  = (op_cls == OC_LDUR) || (op_cls == OC_STUR) || (op_cls == OC_MRS);
          Reg2Loc = (op_cls == OC_STUR) || (op_cls == OC_CBZ) || (op_cls == OC_MRS);
          Branch  = (op_cls == OC_CBZ) || (op_cls == OC_ERET);
          ERet    = (op_cls == OC_ERET);
          case (op_cls)
            OC_R:                   ALUOp = ALUOP_W'(2'b10);
            OC_CBZ, OC_ERET, OC_MRS: ALUOp = ALUOP_W'(2'b01);
            default:                ALUOp = '0;
          endcase
        end
        S_MEM: begin
          ALUSrc   = 1'b1;
          MemRead  = (op_cls == OC_LDUR);
          MemWrite = (op_cls == OC_STUR);
        end
        S_WB: begin
          RegWrite = 1'b1;
          MemtoReg = (op_cls == OC_LDUR);
        end
        S_EXC:   PCWrite = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef MCDEC_EXC_EN
  assign Exc      = !reset && (state_q == S_EXC);
  assign ExcCause = Exc ? cause_q : 2'd0;
`else
  assign Exc      = 1'b0;
  assign ExcCause = 2'd0;
`endif

  assign state_o = state_q;

endmodule
